// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arb_pkg: shared types and sizing helpers for the shared register arbiter
package shared_reg_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  // Owner index width; a single requester still needs a 1-bit index.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: first set request at or after start, wrapping at N-1 -> 0
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] j;

  // Scan from the farthest position back to start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(start) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of a shared q/qb register with bounded burst lock
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 8,
  parameter  int LOCK_MAX = 4,
  localparam int OWNER_W  = owner_w(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [OWNER_W-1:0]      owner,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qb,
  output logic                    upd
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_t             state, state_n;
  logic [OWNER_W-1:0] ptr, ptr_n, owner_n, nxt_start, idle_idx, rel_idx;
  logic [CW-1:0]      cnt, cnt_n;
  logic               idle_found, rel_found, wr, hold;
  logic [WIDTH-1:0]   own_data;

  assign own_data  = wdata[owner*WIDTH +: WIDTH];
  assign nxt_start = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  assign wr        = (state == GRANT) && req[owner];
  assign hold      = wr && lock[owner] && (cnt < CW'(LOCK_MAX));

  rr_pick #(.N(NREQ), .W(OWNER_W)) u_idle_pick (
    .req   (req),
    .start (ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Searching from owner+1 over the full vector leaves the released owner last.
  rr_pick #(.N(NREQ), .W(OWNER_W)) u_rel_pick (
    .req   (req),
    .start (nxt_start),
    .found (rel_found),
    .idx   (rel_idx)
  );

  // Arbitration state, owner, burst counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  // Next grant: fresh pick when idle, hold under lock, else release to the next in line.
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    ptr_n   = ptr;
    if (state == IDLE) begin
      state_n = idle_found ? GRANT : IDLE;
      owner_n = idle_found ? idle_idx : owner;
      cnt_n   = idle_found ? CW'(1) : cnt;
    end else if (hold) begin
      cnt_n   = cnt + 1'b1;
    end else begin
      ptr_n   = nxt_start;
      state_n = rel_found ? GRANT : IDLE;
      owner_n = rel_found ? rel_idx : owner;
      cnt_n   = rel_found ? CW'(1) : '0;
    end
  end

  // Shared storage: only the current owner with req still high writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      qb  <= '1;
      upd <= 1'b0;
    end else begin
      upd <= wr;
      if (wr) begin
        q  <= own_data;
        qb <= ~own_data;
      end
    end
  end

  // Grant decode from the registered owner and state.
  always_comb begin
    busy = (state == GRANT);
    gnt  = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = busy && (int'(owner) == i);
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed stimulus with a write scoreboard checked on every upd pulse
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, lock, gnt;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [1:0]            owner;
  logic                  busy, upd;
  logic [WIDTH-1:0]      q, qb;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .qb    (qb),
    .upd   (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] d);
    wdata[i*WIDTH +: WIDTH] = d;
  endtask

  // Monitor: every upd pulse must match the oldest expected write.
  initial begin
    logic [WIDTH-1:0] e, eb;
    forever begin
      @(posedge clk);
      #2;
      if (rst && upd) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL upd_unexpected: got q=%0h expected no write at %0t", q, $time);
        end else begin
          e  = exp_q.pop_front();
          eb = ~e;
          chk("sb_q", 32'(q), 32'(e));
          chk("sb_qb", 32'(qb), 32'(eb));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; req = '0; lock = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qb", 32'(qb), 32'hFF);
    chk("rst_upd", 32'(upd), 0);
    rst = 1'b1;

    // Round robin from pointer 0, no bubbles.
    req = 4'b1111;
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    tick; chk("rr_g0", 32'(gnt), 32'b0001);
    tick; chk("rr_g1", 32'(gnt), 32'b0010);
    tick; chk("rr_g2", 32'(gnt), 32'b0100);
    tick; chk("rr_g3", 32'(gnt), 32'b1000);
    tick; chk("rr_g4", 32'(gnt), 32'b0001);
    req = '0;
    tick; chk("rr_idle_gnt", 32'(gnt), 0); chk("rr_idle_busy", 32'(busy), 0);

    // Single request: write, one re-grant with req dropped, then idle.
    req = 4'b0100; set_data(2, 8'hA5);
    exp_q.push_back(8'hA5);
    tick; chk("single_gnt", 32'(gnt), 32'b0100); chk("single_owner", 32'(owner), 2);
    tick; chk("single_q", 32'(q), 32'hA5); chk("single_qb", 32'(qb), 32'h5A); chk("single_upd", 32'(upd), 1);
    req = '0;
    tick; chk("single_idle", 32'(gnt), 0); chk("single_upd_off", 32'(upd), 0); chk("single_hold_q", 32'(q), 32'hA5);

    // Drop while granted: no write, release moves pointer to 0.
    req = 4'b1000; set_data(3, 8'h77);
    tick; chk("drop_gnt", 32'(gnt), 32'b1000);
    req = '0;
    tick; chk("drop_gnt_off", 32'(gnt), 0); chk("drop_upd", 32'(upd), 0); chk("drop_q", 32'(q), 32'hA5);
    tick; chk("drop_upd2", 32'(upd), 0);

    // Lock limit: requester 0 holds exactly 4 cycles, then 1, then 0 again.
    req = 4'b0011; lock = 4'b0001; set_data(0, 8'hC0); set_data(1, 8'hC1);
    repeat (4) exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    for (int k = 0; k < 4; k++) begin
      tick; chk($sformatf("lock_g0_%0d", k), 32'(gnt), 32'b0001);
    end
    tick; chk("lock_g1", 32'(gnt), 32'b0010);
    tick; chk("lock_g0_again", 32'(gnt), 32'b0001);
    req = '0; lock = '0;
    tick; chk("lock_idle", 32'(gnt), 0);

    // Back-to-back: req[1] arrives during requester 2's locked burst.
    req = 4'b0100; lock = 4'b0100; set_data(2, 8'hB2);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hB2); exp_q.push_back(8'hB1);
    tick; chk("b2b_g2", 32'(gnt), 32'b0100);
    req = 4'b0110; set_data(1, 8'hB1);
    tick; chk("b2b_hold", 32'(gnt), 32'b0100);
    lock = '0;
    tick; chk("b2b_g1", 32'(gnt), 32'b0010);
    req = 4'b0010;
    tick; chk("b2b_regrant", 32'(gnt), 32'b0010);
    req = '0;
    tick; chk("b2b_idle", 32'(gnt), 0); chk("b2b_q", 32'(q), 32'hB1);

    // Asynchronous reset mid-cycle while requester 1 is granted.
    req = 4'b0010;
    tick; chk("arst_pre_gnt", 32'(gnt), 32'b0010);
    req = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_q", 32'(q), 0);
    chk("arst_qb", 32'(qb), 32'hFF);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_upd", 32'(upd), 0);
    #2 rst = 1'b1;
    tick; chk("post_rst_gnt", 32'(gnt), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register (q/qb pair, D-flip-flop semantics) between NREQ requesters.
- Each requester raises req with its write data. The arbiter grants one requester at a time and loads that requester's data into the shared register.
- Optional lock holds the grant across a multi-cycle burst, bounded by LOCK_MAX.
- Sits between requester logic and the storage flops; it is the sole writer of that register.

Parameters:
- NREQ, 4, number of requesters (1..16)
- WIDTH, 8, width of the shared register
- LOCK_MAX, 4, maximum consecutive granted cycles for one owner while lock is held (>=1)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request, level
- lock  input  NREQ  per-requester burst hold, qualified by req
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant, all-zero when idle
- owner  output  max(1,clog2(NREQ))  index of current grantee, valid when busy
- busy  output  1  high while any grant is active
- q  output  WIDTH  shared register value
- qb  output  WIDTH  bitwise complement of q, always
- upd  output  1  one-cycle pulse, high the cycle after q was loaded

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, gnt=0, owner=0, busy=0, q=0, qb=all ones, upd=0, rr pointer=0, burst counter=0. Takes effect mid-burst with no write completing.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req is high, pick the winner by round-robin: the first requester with req high, searching from the pointer upward with wrap at NREQ-1 -> 0.
  - Next edge: gnt=onehot(winner), owner=winner, state=GRANT, counter=1.
  - Grant latency is 1 cycle from req sampled high.
- GRANT, with o=owner:
  - Write: if req[o] is high this cycle, q<=wdata[o] and qb<=~wdata[o] at the closing edge. upd is high the following cycle.
  - If req[o] is low, there is no write and the grant is released.
  - Hold: if req[o] and lock[o] are both high and counter<LOCK_MAX, stay in GRANT with the same owner and increment counter.
  - Release (all other cases): pointer<=o+1 (wraps).
    - If any req other than o is high, the next edge grants the round-robin winner searched from o+1, back-to-back with no IDLE bubble, and counter=1.
    - Otherwise the next edge goes to IDLE with gnt=0.
  - The released owner is searched last. If o is the only requester it is re-granted, so one requester saturates at one write per cycle.
- Lock limit: after LOCK_MAX consecutive granted cycles, release is forced even if lock[o] is high. The owner can win again only after the other pending requesters are served.
- Requests arriving while a grant is held are not lost; they are level-held and considered at the next release.
- A requester must hold req (and stable wdata) until it sees gnt. gnt arriving after req has dropped is a protocol error; the arbiter simply releases.
- NREQ=1: the pointer is always 0 and owner is 1 bit, tied to 0.
- upd is never high without a preceding write. q holds its value through IDLE.

Decomposition:
- Package shared_reg_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - OWNER_W = max(1, clog2(NREQ)) localparam function
- Sub-module rr_pick (combinational): inputs req vector and start index; outputs a found flag and the winner index. Instantiated once for the IDLE search and once for the release search (from o+1, or equivalently with o masked).

Test Plan:
- Reset value: rst low asynchronously mid-cycle with gnt=0010 -> gnt=0000, q=00, qb=FF, busy=0 immediately, without waiting for an edge.
- Single request: req=0100, wdata[2]=A5 -> gnt=0100 next cycle, q=A5/qb=5A the cycle after, upd pulses once, then IDLE.
- Round-robin: req=1111 held, lock=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubbles. q tracks each requester's data.
- Lock limit: req=0011, lock=0001, LOCK_MAX=4 -> gnt=0001 for exactly 4 cycles, then 0010. Requester 0 regains the grant only after requester 1 is served.
- Drop while granted: req[3] deasserts in its granted cycle -> q unchanged, upd stays 0, release next edge with the pointer set to 0.
- Back-to-back arrival: req[1] rises while requester 2 holds the lock -> req[1] is granted on the first edge after requester 2 releases, and no request is lost.
